// File: rtl/vend_ctrl_fsm.sv
// Vending-machine transaction controller: goods selection, payment, change/refund and dispense.
// Optional PAYMENT inactivity timeout is built only when VEND_TIMEOUT_EN is defined.
module vend_ctrl_fsm #(
  parameter int unsigned CHANGE_CYCLES  = 50_000_000,
  parameter int unsigned TEMP_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_start,
  input  logic       key_confirm,
  input  logic       key_cancel,
  input  logic [2:0] goods_sel,
  input  logic       coin_valid,
  input  logic [1:0] coin_sel,
  output logic [5:0] state,
  output logic [2:0] out_goods_high,
  output logic [2:0] out_goods_low,
  output logic [1:0] out_goods_num,
  output logic [4:0] total_price,
  output logic [7:0] paid_amt,
  output logic [7:0] change_amt,
  output logic       refund,
  output logic       dispense
);

  typedef enum logic [5:0] {
    S_IDLE      = 6'h01,
    S_GOODS_ONE = 6'h02,
    S_GOODS_TWO = 6'h04,
    S_PAYMENT   = 6'h08,
    S_CHANGE    = 6'h10,
    S_TEMP      = 6'h20
  } state_e;

  if (CHANGE_CYCLES == 0 || TEMP_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("vend_ctrl_fsm: cycle parameters must be >= 1");
  end

  state_e      state_q, state_d;
  logic [2:0]  high_q, high_d;
  logic [2:0]  low_q, low_d;
  logic [1:0]  num_q, num_d;
  logic [4:0]  total_q, total_d;
  logic [7:0]  paid_q, paid_d;
  logic [7:0]  change_q, change_d;
  logic        refund_q, refund_d;
  logic        dispense_q, dispense_d;
  logic [31:0] cnt_q, cnt_d;

  logic [7:0]  coin_value;
  logic [8:0]  paid_sum;
  logic [7:0]  paid_next;
  logic [4:0]  price_sum;
  logic        clear_txn;

  always_comb begin
    coin_value = 8'd1;
    case (coin_sel)
      2'b00:   coin_value = 8'd1;
      2'b01:   coin_value = 8'd5;
      2'b10:   coin_value = 8'd10;
      default: coin_value = 8'd20;
    endcase
  end

  assign paid_sum  = {1'b0, paid_q} + (coin_valid ? {1'b0, coin_value} : 9'd0);
  assign paid_next = paid_sum[8] ? 8'hFF : paid_sum[7:0];
  // Payment decisions use the live goods sum; total_price itself lags it by one cycle.
  assign price_sum = {2'b00, high_q} + {2'b00, low_q};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    high_d     = high_q;
    low_d      = low_q;
    num_d      = num_q;
    total_d    = price_sum;
    paid_d     = paid_q;
    change_d   = change_q;
    refund_d   = refund_q;
    dispense_d = 1'b0;
    cnt_d      = cnt_q;
    clear_txn  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_start && !key_confirm && !key_cancel) state_d = S_GOODS_ONE;
      end
      S_GOODS_ONE: begin
        if (key_cancel) begin
          clear_txn = 1'b1;
        end else if (key_confirm && goods_sel != 3'd0) begin
          high_d  = goods_sel;
          num_d   = 2'd1;
          state_d = S_GOODS_TWO;
        end
      end
      S_GOODS_TWO: begin
        if (key_cancel) begin
          clear_txn = 1'b1;
        end else if (key_confirm) begin
          low_d   = goods_sel;
          num_d   = (goods_sel != 3'd0) ? 2'd2 : 2'd1;
          cnt_d   = 32'd0;
          state_d = S_PAYMENT;
        end
      end
      S_PAYMENT: begin
        paid_d = paid_next;
        if (key_cancel) begin
          change_d = paid_next;
          refund_d = 1'b1;
          cnt_d    = 32'd0;
          state_d  = S_CHANGE;
        end else if (coin_valid && paid_next >= {3'b000, price_sum}) begin
          change_d = paid_next - {3'b000, price_sum};
          refund_d = 1'b0;
          cnt_d    = 32'd0;
          state_d  = S_CHANGE;
        end
`ifdef VEND_TIMEOUT_EN
        else if (coin_valid) begin
          cnt_d = 32'd0;
        end else if (cnt_q >= TIMEOUT_CYCLES - 32'd1) begin
          change_d = paid_q;
          refund_d = 1'b1;
          cnt_d    = 32'd0;
          state_d  = S_CHANGE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      S_CHANGE: begin
        if (cnt_q >= CHANGE_CYCLES - 32'd1) begin
          cnt_d      = 32'd0;
          dispense_d = !refund_q;
          state_d    = S_TEMP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_TEMP: begin
        if (cnt_q >= TEMP_CYCLES - 32'd1) clear_txn = 1'b1;
        else                              cnt_d = cnt_q + 32'd1;
      end
      default: clear_txn = 1'b1;
    endcase

    if (clear_txn) begin
      state_d  = S_IDLE;
      high_d   = 3'd0;
      low_d    = 3'd0;
      num_d    = 2'd0;
      total_d  = 5'd0;
      paid_d   = 8'd0;
      change_d = 8'd0;
      refund_d = 1'b0;
      cnt_d    = 32'd0;
    end
  end

  // Reset is synchronous and active-high even though the port carries an _n suffix.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      state_q    <= S_IDLE;
      high_q     <= 3'd0;
      low_q      <= 3'd0;
      num_q      <= 2'd0;
      total_q    <= 5'd0;
      paid_q     <= 8'd0;
      change_q   <= 8'd0;
      refund_q   <= 1'b0;
      dispense_q <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q    <= state_d;
      high_q     <= high_d;
      low_q      <= low_d;
      num_q      <= num_d;
      total_q    <= total_d;
      paid_q     <= paid_d;
      change_q   <= change_d;
      refund_q   <= refund_d;
      dispense_q <= dispense_d;
      cnt_q      <= cnt_d;
    end
  end

  assign state          = state_q;
  assign out_goods_high = high_q;
  assign out_goods_low  = low_q;
  assign out_goods_num  = num_q;
  assign total_price    = total_q;
  assign paid_amt       = paid_q;
  assign change_amt     = change_q;
  assign refund         = refund_q;
  assign dispense       = dispense_q;

endmodule

// File: tb/tb_vend_ctrl_fsm.sv
// Self-checking bench for vend_ctrl_fsm: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_vend_ctrl_fsm;

  localparam int CHG = 4;
  localparam int TMP = 3;
  localparam int TO  = 10;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_start, key_confirm, key_cancel;
  logic [2:0] goods_sel;
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic [5:0] state;
  logic [2:0] out_goods_high, out_goods_low;
  logic [1:0] out_goods_num;
  logic [4:0] total_price;
  logic [7:0] paid_amt, change_amt;
  logic       refund, dispense;

  int n_checks = 0;
  int n_errors = 0;
  bit saw_disp = 0;

  // Reference model: phase index 0..5 follows the order IDLE, GOODS_one, GOODS_two,
  // PAYMENT, CHANGE, TEMP; timers count remaining cycles downward.
  int m_phase, m_high, m_low, m_num, m_total, m_paid, m_change, m_refund, m_disp;
  int m_left, m_idle_left;

  vend_ctrl_fsm #(
    .CHANGE_CYCLES (CHG),
    .TEMP_CYCLES   (TMP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .key_start     (key_start),
    .key_confirm   (key_confirm),
    .key_cancel    (key_cancel),
    .goods_sel     (goods_sel),
    .coin_valid    (coin_valid),
    .coin_sel      (coin_sel),
    .state         (state),
    .out_goods_high(out_goods_high),
    .out_goods_low (out_goods_low),
    .out_goods_num (out_goods_num),
    .total_price   (total_price),
    .paid_amt      (paid_amt),
    .change_amt    (change_amt),
    .refund        (refund),
    .dispense      (dispense)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int coin_val(input int cs);
    case (cs)
      0:       return 1;
      1:       return 5;
      2:       return 10;
      default: return 20;
    endcase
  endfunction

  task automatic m_clear();
    m_phase  = 0;
    m_high   = 0;
    m_low    = 0;
    m_num    = 0;
    m_paid   = 0;
    m_change = 0;
    m_refund = 0;
  endtask

  task automatic m_to_change(input int chg, input int rf);
    m_change = chg;
    m_refund = rf;
    m_phase  = 4;
    m_left   = CHG;
  endtask

  task automatic model_step(input bit rst, input bit st, input bit cf, input bit cn,
                            input int sel, input bit cv, input int cs);
    int coin, sum, pn;
    bit clr;
    if (rst) begin
      m_clear();
      m_total = 0;
      m_disp  = 0;
      m_left  = 0;
      return;
    end
    coin   = cv ? coin_val(cs) : 0;
    sum    = m_high + m_low;
    pn     = (m_paid + coin > 255) ? 255 : m_paid + coin;
    clr    = 0;
    m_disp = 0;
    case (m_phase)
      0: if (st && !cf && !cn) m_phase = 1;
      1: begin
        if (cn) clr = 1;
        else if (cf && sel != 0) begin m_high = sel; m_num = 1; m_phase = 2; end
      end
      2: begin
        if (cn) clr = 1;
        else if (cf) begin
          m_low       = sel;
          m_num       = (sel != 0) ? 2 : 1;
          m_phase     = 3;
          m_idle_left = TO;
        end
      end
      3: begin
        if (cn) begin
          m_paid = pn;
          m_to_change(pn, 1);
        end else if (pn >= sum) begin
          m_paid = pn;
          m_to_change(pn - sum, 0);
        end else begin
          m_paid = pn;
`ifdef VEND_TIMEOUT_EN
          if (cv) m_idle_left = TO;
          else begin
            m_idle_left--;
            if (m_idle_left == 0) m_to_change(m_paid, 1);
          end
`endif
        end
      end
      4: begin
        m_left--;
        if (m_left == 0) begin m_phase = 5; m_left = TMP; m_disp = m_refund ? 0 : 1; end
      end
      default: begin
        m_left--;
        if (m_left == 0) clr = 1;
      end
    endcase
    m_total = clr ? 0 : sum;
    if (clr) m_clear();
  endtask

  task automatic check_model();
    check("state",    state,          32'(1 << m_phase));
    check("high",     out_goods_high, m_high);
    check("low",      out_goods_low,  m_low);
    check("num",      out_goods_num,  m_num);
    check("total",    total_price,    m_total);
    check("paid",     paid_amt,       m_paid);
    check("change",   change_amt,     m_change);
    check("refund",   refund,         m_refund);
    check("dispense", dispense,       m_disp);
  endtask

  task automatic cycle(input bit rst, input bit st, input bit cf, input bit cn,
                       input int sel, input bit cv, input int cs);
    @(negedge sys_clk);
    sys_rst_n   = rst;
    key_start   = st;
    key_confirm = cf;
    key_cancel  = cn;
    goods_sel   = 3'(sel);
    coin_valid  = cv;
    coin_sel    = 2'(cs);
    @(posedge sys_clk);
    model_step(rst, st, cf, cn, sel, cv, cs);
    #1;
    check_model();
    if (dispense) saw_disp = 1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic start();           cycle(0, 1, 0, 0, 0, 0, 0);  endtask
  task automatic confirm(input int s); cycle(0, 0, 1, 0, s, 0, 0); endtask
  task automatic cancel();          cycle(0, 0, 0, 1, 0, 0, 0);  endtask
  task automatic coin(input int cs); cycle(0, 0, 0, 0, 0, 1, cs); endtask

  initial begin
    sys_rst_n = 1'b1; key_start = 0; key_confirm = 0; key_cancel = 0;
    goods_sel = 0; coin_valid = 0; coin_sel = 0;
    m_clear(); m_total = 0; m_disp = 0; m_left = 0; m_idle_left = 0;

    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 5, 1, 3);
    check("rst_state", state, 32'h01);
    check("rst_paid",  paid_amt, 0);

    // Single item, code 3, paid with a 5-yuan coin.
    start();
    confirm(3);
    confirm(0);
    check("si_state_pay", state, 32'h08);
    check("si_total", total_price, 3);
    check("si_num", out_goods_num, 1);
    coin(1);
    check("si_state_chg", state, 32'h10);
    check("si_paid", paid_amt, 5);
    check("si_change", change_amt, 2);
    tick(3);
    check("si_still_chg", state, 32'h10);
    tick(1);
    check("si_temp", state, 32'h20);
    check("si_disp", dispense, 1);
    tick(1);
    check("si_disp_off", dispense, 0);
    tick(2);
    check("si_idle", state, 32'h01);
    check("si_clr_high", out_goods_high, 0);
    check("si_clr_change", change_amt, 0);

    // Coin in IDLE is ignored.
    coin(3);
    check("idle_coin", paid_amt, 0);

    // Two items, codes 7 and 6 (13 yuan); coins 10, 1, 5.
    start(); confirm(7); confirm(6);
    coin(2); check("ti_paid10", paid_amt, 10);
    coin(0); check("ti_paid11", paid_amt, 11);
    check("ti_total", total_price, 13);
    coin(1); check("ti_paid16", paid_amt, 16);
    check("ti_state", state, 32'h10);
    check("ti_change", change_amt, 3);
    check("ti_num", out_goods_num, 2);
    coin(3);
    check("chg_coin", paid_amt, 16);
    tick(6);
    check("ti_idle", state, 32'h01);

    // Two items, codes 7 and 7 (14 yuan), exact 14+2 overpay.
    start(); confirm(7); confirm(7);
    coin(2); coin(0); coin(1);
    check("t7_change", change_amt, 2);
    tick(7);

    // Cancel with a simultaneous 20-yuan coin.
    saw_disp = 0;
    start(); confirm(5); confirm(0);
    coin(0);
    cycle(0, 0, 0, 1, 0, 1, 3);
    check("cx_state", state, 32'h10);
    check("cx_change", change_amt, 21);
    check("cx_refund", refund, 1);
    tick(7);
    check("cx_nodisp", saw_disp, 0);
    check("cx_idle", state, 32'h01);

    // Selection guards.
    start();
    confirm(0);
    check("g_sel0", state, 32'h02);
    confirm(4);
    cancel();
    check("g_cancel", state, 32'h01);
    check("g_high", out_goods_high, 0);
    check("g_num", out_goods_num, 0);

    // Reset in the middle of PAYMENT.
    start(); confirm(7); confirm(0);
    coin(0); coin(1);
    check("r_paid6", paid_amt, 6);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("r_state", state, 32'h01);
    check("r_paid", paid_amt, 0);
    check("r_total", total_price, 0);

`ifdef VEND_TIMEOUT_EN
    start(); confirm(3); confirm(0); coin(0);
    tick(9);
    check("to_wait", state, 32'h08);
    tick(1);
    check("to_state", state, 32'h10);
    check("to_change", change_amt, 1);
    check("to_refund", refund, 1);
    tick(7);
    start(); confirm(3); confirm(0); coin(0);
    tick(8);
    coin(0);
    tick(9);
    check("to_delay", state, 32'h08);
    tick(1);
    check("to_late", state, 32'h10);
    check("to_late_chg", change_amt, 2);
    tick(7);
`else
    start(); confirm(3); confirm(0); coin(0);
    tick(120);
    check("no_timeout", state, 32'h08);
    cancel();
    tick(7);
`endif

    // Randomized traffic; at most one key per cycle, coins and resets independent.
    for (int i = 0; i < 4000; i++) begin
      int k;
      bit rst, cv;
      rst = ($urandom_range(0, 199) == 0);
      k   = $urandom_range(0, 9);
      cv  = ($urandom_range(0, 3) == 0);
      cycle(rst, k < 2, (k == 2) || (k == 3), k == 4,
            $urandom_range(0, 7), cv, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
